// File: rtl/ysyx_25030093_pkg.sv
// ysyx_25030093_pkg: shared encodings and constants for the ysyx_25030093 core
package ysyx_25030093_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT_R  = 3'd2,
        HOLD    = 3'd3,
        WAIT_PC = 3'd4,
        ERR     = 3'd5
    } ifu_state_t;
    localparam logic [1:0]  RESP_OK          = 2'b00;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_25030093_ifu.sv
// ysyx_25030093_ifu: PC owner and single-outstanding instruction fetch for the multi-cycle core
module ysyx_25030093_ifu
    import ysyx_25030093_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,
    output logic        imem_rready,
    output logic        out_valid,
    input  logic        in_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    input  logic        pc_update_valid,
    input  logic [31:0] pc_next,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);
    ifu_state_t state, state_n;
    logic [31:0] pc;
    logic misaligned;

    assign misaligned   = pc[1:0] != 2'b00;
    assign imem_arvalid = state == REQ && !misaligned;
    assign imem_araddr  = pc;
    assign imem_rready  = state == WAIT_R;
    assign out_valid    = state == HOLD;
    assign out_pc       = pc;
    // ERR is terminal, so the state itself keeps the fault sticky; a bad PC shows up already in REQ
    assign fetch_err    = state == ERR || (state == REQ && misaligned);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = REQ;
            REQ:     state_n = misaligned ? ERR : (imem_arready ? WAIT_R : REQ);
            WAIT_R:  state_n = imem_rvalid ? (imem_rresp == RESP_OK ? HOLD : ERR) : WAIT_R;
            HOLD:    state_n = in_ready ? WAIT_PC : HOLD;
            WAIT_PC: state_n = pc_update_valid ? REQ : WAIT_PC;
            ERR:     state_n = ERR;
            default: state_n = ERR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            out_inst  <= '0;
            fetch_cnt <= '0;
        end else begin
            state <= state_n;
            if (state == WAIT_PC && pc_update_valid)
                pc <= pc_next;
            if (state == WAIT_R && imem_rvalid && imem_rresp == RESP_OK) begin
                out_inst  <= imem_rdata;
                fetch_cnt <= fetch_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// tb_ysyx_25030093_ifu: scoreboard bench with a delay/error-programmable instruction memory
module tb_ysyx_25030093_ifu;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clock, reset;
    logic        imem_arvalid, imem_arready, imem_rvalid, imem_rready;
    logic [31:0] imem_araddr, imem_rdata;
    logic [1:0]  imem_rresp;
    logic        out_valid, in_ready, pc_update_valid, fetch_err;
    logic [31:0] out_inst, out_pc, pc_next, fetch_cnt;

    int n_tests = 0, n_fail = 0;
    logic [63:0] sb_q[$];

    int ar_delay = 0, r_delay = 0, ar_cnt = 0, r_cnt = 0;
    logic [1:0]  resp_cfg = 2'b00;
    logic        r_pend = 0, ar_hs = 0, r_hs = 0, rst_cap = 1;
    logic [31:0] r_addr = '0, cap_addr = '0;

    ysyx_25030093_ifu dut (
        .clock(clock), .reset(reset),
        .imem_arvalid(imem_arvalid), .imem_araddr(imem_araddr), .imem_arready(imem_arready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rresp(imem_rresp),
        .imem_rready(imem_rready),
        .out_valid(out_valid), .in_ready(in_ready), .out_inst(out_inst), .out_pc(out_pc),
        .pc_update_valid(pc_update_valid), .pc_next(pc_next),
        .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a == RST_PC ? 32'h0010_0093 : a ^ 32'h1234_5013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // memory model: drives at negedge+1, captures the coming posedge's handshakes at negedge+2
    initial begin
        imem_arready = 0; imem_rvalid = 0; imem_rdata = '0; imem_rresp = '0;
        forever begin
            @(negedge clock);
            #1;
            if (rst_cap) begin
                r_pend = 0; ar_cnt = 0;
            end else begin
                if (r_hs) r_pend = 0;
                if (ar_hs) begin r_pend = 1; r_cnt = 0; ar_cnt = 0; r_addr = cap_addr; end
            end
            imem_arready = imem_arvalid && !r_pend && ar_cnt >= ar_delay;
            if (imem_arvalid && !imem_arready) ar_cnt++;
            imem_rvalid = r_pend && r_cnt >= r_delay;
            imem_rdata  = imem_rvalid ? mem_word(r_addr) : 32'h0;
            imem_rresp  = imem_rvalid ? resp_cfg : 2'b00;
            if (r_pend && !imem_rvalid) r_cnt++;
            #1;
            ar_hs = imem_arvalid && imem_arready;
            r_hs = imem_rvalid && imem_rready;
            rst_cap = reset;
            cap_addr = imem_araddr;
        end
    end

    // scoreboard: compare each decode handshake against the oldest expected {pc, inst}
    initial begin
        forever begin
            @(negedge clock);
            #3;
            if (!reset && out_valid && in_ready) begin
                if (sb_q.size() == 0) chk("sb_unexpected", 32'h1, 32'h0);
                else begin
                    logic [63:0] e;
                    e = sb_q.pop_front();
                    chk("sb_pc", out_pc, e[63:32]);
                    chk("sb_inst", out_inst, e[31:0]);
                end
            end
        end
    end

    task automatic run_fetch(input logic [31:0] pc_exp, input int hold, input logic [31:0] nxt,
                             input bit spur);
        int n, av, lat;
        logic [31:0] cnt0;
        cnt0 = fetch_cnt;
        sb_q.push_back({pc_exp, mem_word(pc_exp)});
        n = 0; av = 0; lat = 0;
        while (!out_valid && n < 200) begin
            if (imem_arvalid) begin
                av++;
                chk("araddr", imem_araddr, pc_exp);
            end
            if (av > 0) lat++;
            tick();
            n++;
        end
        chk("out_valid_seen", out_valid, 1);
        chk("ar_cycles", av, ar_delay + 1);
        chk("latency", lat, ar_delay + r_delay + 2);
        for (int i = 0; i < hold; i++) begin
            if (spur) begin pc_update_valid = 1; pc_next = 32'hdead_0000; end
            chk("hold_valid", out_valid, 1);
            chk("hold_inst", out_inst, mem_word(pc_exp));
            chk("hold_pc", out_pc, pc_exp);
            tick();
        end
        pc_update_valid = 0;
        in_ready = 1;
        tick();
        in_ready = 0;
        chk("wait_pc_inst", out_inst, mem_word(pc_exp));
        chk("wait_pc_valid", out_valid, 0);
        chk("fetch_cnt", fetch_cnt, cnt0 + 32'd1);
        pc_update_valid = 1;
        pc_next = nxt;
        tick();
        pc_update_valid = 0;
    endtask

    initial begin
        int n;
        logic [31:0] inst_prev, cnt_prev;
        reset = 1; in_ready = 0; pc_update_valid = 0; pc_next = '0;
        tick(); tick();
        chk("rst_arvalid", imem_arvalid, 0);
        chk("rst_rready", imem_rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc", out_pc, RST_PC);
        chk("rst_inst", out_inst, 0);
        chk("rst_cnt", fetch_cnt, 0);
        chk("rst_err", fetch_err, 0);
        reset = 0;
        tick();
        chk("first_arvalid", imem_arvalid, 1);

        // zero-wait fetch, decode stalls 5 cycles in HOLD
        run_fetch(RST_PC, 5, 32'h8000_0004, 0);
        // stalled memory
        ar_delay = 3; r_delay = 4;
        run_fetch(32'h8000_0004, 0, 32'h8000_0008, 0);
        chk("cnt_after_two", fetch_cnt, 2);

        // error response
        ar_delay = 0; r_delay = 1; resp_cfg = 2'b10;
        inst_prev = out_inst; cnt_prev = fetch_cnt;
        n = 0;
        while (!fetch_err && n < 50) begin tick(); n++; end
        chk("resp_err", fetch_err, 1);
        for (int i = 0; i < 4; i++) begin
            chk("err_arvalid", imem_arvalid, 0);
            chk("err_out_valid", out_valid, 0);
            chk("err_sticky", fetch_err, 1);
            tick();
        end
        chk("err_inst_kept", out_inst, inst_prev);
        chk("err_cnt_kept", fetch_cnt, cnt_prev);
        resp_cfg = 2'b00; r_delay = 0;
        reset = 1;
        tick();
        chk("err_rst_err", fetch_err, 0);
        chk("err_rst_pc", out_pc, RST_PC);
        chk("err_rst_cnt", fetch_cnt, 0);
        reset = 0;
        tick();
        chk("err_rst_arvalid", imem_arvalid, 1);

        // misaligned next PC, spurious pc_update_valid during HOLD
        run_fetch(RST_PC, 3, 32'h8000_0006, 1);
        chk("mis_pc", out_pc, 32'h8000_0006);
        chk("mis_err", fetch_err, 1);
        chk("mis_arvalid", imem_arvalid, 0);
        tick();
        chk("mis_err_sticky", fetch_err, 1);
        chk("mis_arvalid2", imem_arvalid, 0);
        chk("mis_out_valid", out_valid, 0);

        // reset landing in WAIT_R together with rvalid
        reset = 1; tick(); reset = 0; tick();
        run_fetch(RST_PC, 0, 32'h8000_0008, 0);
        r_delay = 2;
        n = 0;
        while (!imem_rready && n < 50) begin tick(); n++; end
        tick(); tick();
        chk("wr_rready", imem_rready, 1);
        reset = 1;
        tick();
        chk("wr_rst_cnt", fetch_cnt, 0);
        chk("wr_rst_inst", out_inst, 0);
        chk("wr_rst_pc", out_pc, RST_PC);
        chk("wr_rst_valid", out_valid, 0);
        reset = 0;
        r_delay = 0;
        tick();
        run_fetch(RST_PC, 0, 32'h8000_0004, 0);
        chk("wr_recover_cnt", fetch_cnt, 1);
        tick();
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
